// File: rtl/lsu_mem_initiator_if.sv
// LSU memory initiator bundle: execute-stage op in, result out,
// and the request/response port toward the data memory.
interface lsu_mem_initiator_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_is_load;
   logic        in_is_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rdata;
   logic        out_err;
   logic [1:0]  out_err_cause;

   logic        lsu_reqValid;
   logic        lsu_respValid;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic [31:0] lsu_rdata;

   modport master (
      input  in_valid,
      input  in_is_load,
      input  in_is_store,
      input  in_funct3,
      input  in_addr,
      input  in_wdata,
      output in_ready,
      output out_valid,
      input  out_ready,
      output out_rdata,
      output out_err,
      output out_err_cause,
      output lsu_reqValid,
      input  lsu_respValid,
      output lsu_addr,
      output lsu_wen,
      output lsu_wdata,
      output lsu_wmask,
      input  lsu_rdata
   );

   modport slave (
      output in_valid,
      output in_is_load,
      output in_is_store,
      output in_funct3,
      output in_addr,
      output in_wdata,
      input  in_ready,
      input  out_valid,
      output out_ready,
      input  out_rdata,
      input  out_err,
      input  out_err_cause,
      input  lsu_reqValid,
      output lsu_respValid,
      input  lsu_addr,
      input  lsu_wen,
      input  lsu_wdata,
      input  lsu_wmask,
      output lsu_rdata
   );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: aligns one op onto a word memory port,
// waits for the response with a timeout, and returns the result.
module lsu_mem_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   lsu_mem_initiator_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0] addr_q, addr_d;
   logic        wen_q, wen_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;

   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [1:0]  cause_q, cause_d;

   logic [1:0]  off;
   logic        ld_f3_ok;
   logic        st_f3_ok;
   logic        illegal;
   logic        misal;
   logic [3:0]  st_mask;
   logic [31:0] st_wdata;
   logic [31:0] ld_shift;
   logic [31:0] ld_data;

   // Decode of the offered op
   always_comb begin
      off      = bus.in_addr[1:0];
      ld_f3_ok = bus.in_funct3 inside {3'b000, 3'b001, 3'b010,
                                       3'b100, 3'b101};
      st_f3_ok = bus.in_funct3 inside {3'b000, 3'b001, 3'b010};
      illegal  = (bus.in_is_load == bus.in_is_store)
               | (bus.in_is_load  & ~ld_f3_ok)
               | (bus.in_is_store & ~st_f3_ok);
      misal    = 1'b0;
      st_mask  = 4'b1111;
      unique case (1'b1)
         (bus.in_funct3[1:0] == 2'b00): begin
            st_mask = 4'b0001 << off;
         end
         (bus.in_funct3[1:0] == 2'b01): begin
            st_mask = 4'b0011 << off;
            misal   = off[0];
         end
         default: begin
            st_mask = 4'b1111;
            misal   = (off != 2'b00);
         end
      endcase
      st_wdata = bus.in_wdata << {off, 3'b000};
   end

   // Lane extraction and extension of the returned word
   always_comb begin
      ld_shift = bus.lsu_rdata >> {off_q, 3'b000};
      unique case (f3_q)
         3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_data = {24'd0, ld_shift[7:0]};
         3'b101:  ld_data = {16'd0, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cause_d = cause_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (illegal || misal) begin
                  rdata_d = 32'd0;
                  err_d   = 1'b1;
                  cause_d = illegal ? 2'b10 : 2'b01;
                  state_d = DONE;
               end else begin
                  addr_d  = {bus.in_addr[31:2], 2'b00};
                  wen_d   = bus.in_is_store;
                  wdata_d = bus.in_is_store ? st_wdata : 32'd0;
                  wmask_d = bus.in_is_store ? st_mask : 4'b0000;
                  f3_d    = bus.in_funct3;
                  off_d   = off;
                  cnt_d   = '0;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (bus.lsu_respValid) begin
               rdata_d = wen_q ? 32'd0 : ld_data;
               err_d   = 1'b0;
               cause_d = 2'b00;
               state_d = DONE;
            end else begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
               // This cycle is the last one the request may stay open
               if (cnt_q >= CNT_LAST) begin
                  rdata_d = 32'd0;
                  err_d   = 1'b1;
                  cause_d = 2'b11;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= 32'd0;
         wen_q   <= 1'b0;
         wdata_q <= 32'd0;
         wmask_q <= 4'b0000;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cause_q <= cause_d;
      end
   end

   assign bus.in_ready      = (state_q == IDLE);
   assign bus.lsu_reqValid  = (state_q == REQ);
   assign bus.out_valid     = (state_q == DONE);
   assign bus.lsu_addr      = addr_q;
   assign bus.lsu_wen       = wen_q;
   assign bus.lsu_wdata     = wdata_q;
   assign bus.lsu_wmask     = wmask_q;
   assign bus.out_rdata     = rdata_q;
   assign bus.out_err       = err_q;
   assign bus.out_err_cause = cause_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed and random ops against an
// arithmetic reference model, with a cycle-stepped responder.
module tb_lsu_mem_initiator;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   lsu_mem_initiator_if bus();

   lsu_mem_initiator #(
      .TIMEOUT_CYCLES(TO),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_op(input logic ld, input logic st,
                        input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int dly,
                        input int hold);
      int          nb, off, nreq, lat, exp_req;
      bit          ill, mis, go, tmo, done;
      longint      v, m;
      logic [31:0] e_addr, e_wd, e_rd;
      logic [3:0]  e_mask;
      logic        e_err;
      logic [1:0]  e_cause;

      nb  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off = int'(addr[1:0]);
      ill = (ld == st)
         || (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
         || (st && !(f3 inside {3'd0, 3'd1, 3'd2}));
      mis = (off % nb) != 0;
      go  = !ill && !mis;
      tmo = go && (dly >= TO);

      e_addr = addr & ~32'h3;
      e_mask = st ? 4'(((1 << nb) - 1) << off) : 4'b0000;
      e_wd   = st ? (wd << (8 * off)) : 32'd0;

      m = (64'd1 << (8 * nb)) - 1;
      v = (longint'(rd) >> (8 * off)) & m;
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~m;

      if (!go) begin
         e_err = 1'b1; e_cause = ill ? 2'b10 : 2'b01; e_rd = 32'd0;
      end else if (tmo) begin
         e_err = 1'b1; e_cause = 2'b11; e_rd = 32'd0;
      end else begin
         e_err = 1'b0; e_cause = 2'b00; e_rd = st ? 32'd0 : v[31:0];
      end
      exp_req = !go ? 0 : (tmo ? TO : dly + 1);

      for (int k = 0; k < 10 && !bus.in_ready; k++) @(posedge clk) #1;
      chk("in_ready_idle", bus.in_ready, 1);

      bus.in_valid    = 1'b1;
      bus.in_is_load  = ld;
      bus.in_is_store = st;
      bus.in_funct3   = f3;
      bus.in_addr     = addr;
      bus.in_wdata    = wd;
      @(posedge clk) #1;
      bus.in_valid = 1'b0;

      chk("req_t1", bus.lsu_reqValid, go);
      nreq = 0; lat = 0; done = 0;
      for (int c = 0; c < 20; c++) begin
         bus.lsu_respValid = 1'b0;
         lat++;
         if (bus.out_valid) begin
            done = 1;
            break;
         end
         if (bus.lsu_reqValid) begin
            chk("lsu_addr", bus.lsu_addr, e_addr);
            chk("lsu_wen", bus.lsu_wen, st);
            chk("lsu_wdata", bus.lsu_wdata, e_wd);
            chk("lsu_wmask", bus.lsu_wmask, e_mask);
            bus.lsu_respValid = (nreq >= dly);
            bus.lsu_rdata     = rd;
            nreq++;
         end
         @(posedge clk) #1;
      end
      bus.lsu_respValid = 1'b0;

      chk("done_seen", done, 1);
      chk("req_cycles", nreq, exp_req);
      chk("latency", lat, exp_req + 1);
      chk("out_err", bus.out_err, e_err);
      chk("out_cause", bus.out_err_cause, e_cause);
      chk("out_rdata", bus.out_rdata, e_rd);
      chk("req_drop", bus.lsu_reqValid, 0);
      chk("in_ready_busy", bus.in_ready, 0);

      for (int h = 0; h < hold; h++) begin
         @(posedge clk) #1;
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_rdata", bus.out_rdata, e_rd);
         chk("bp_in_ready", bus.in_ready, 0);
      end

      bus.out_ready = 1'b1;
      @(posedge clk) #1;
      bus.out_ready = 1'b0;
      chk("valid_drop", bus.out_valid, 0);
      chk("in_ready_back", bus.in_ready, 1);
   endtask

   initial begin
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] a;
      int          d;

      bus.in_valid      = 1'b0;
      bus.in_is_load    = 1'b0;
      bus.in_is_store   = 1'b0;
      bus.in_funct3     = 3'b000;
      bus.in_addr       = 32'd0;
      bus.in_wdata      = 32'd0;
      bus.out_ready     = 1'b0;
      bus.lsu_respValid = 1'b0;
      bus.lsu_rdata     = 32'd0;

      #12;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_req", bus.lsu_reqValid, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_rdata", bus.out_rdata, 0);
      chk("rst_err", {bus.out_err, bus.out_err_cause}, 0);
      chk("rst_lsu", {bus.lsu_wen, bus.lsu_wmask}, 0);
      chk("rst_addr", bus.lsu_addr | bus.lsu_wdata, 0);
      @(posedge clk) #1;
      rst = 1'b1;

      do_op(1, 0, 3'b010, 32'h8000_0004, 0, 32'hDEAD_BEEF, 0, 0);
      do_op(1, 0, 3'b000, 32'h8000_0003, 0, 32'h80FF_1234, 0, 0);
      do_op(1, 0, 3'b100, 32'h8000_0003, 0, 32'h80FF_1234, 0, 0);
      do_op(1, 0, 3'b101, 32'h8000_0002, 0, 32'h80FF_1234, 0, 0);
      do_op(0, 1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 0, 3, 0);
      do_op(1, 0, 3'b010, 32'h8000_0002, 0, 32'h1111_1111, 0, 0);
      do_op(1, 0, 3'b011, 32'h8000_0000, 0, 32'h1111_1111, 0, 0);
      do_op(1, 1, 3'b010, 32'h8000_0000, 0, 32'h1111_1111, 0, 0);
      do_op(1, 0, 3'b010, 32'h8000_0010, 0, 32'h2222_2222, 255, 0);
      do_op(0, 1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 0, 1, 0);
      do_op(1, 0, 3'b010, 32'h8000_0020, 0, 32'h1357_9BDF, 2, 5);
      do_op(0, 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 0, TO - 1, 1);

      // Reset pulse while a request is open
      bus.in_valid    = 1'b1;
      bus.in_is_load  = 1'b1;
      bus.in_is_store = 1'b0;
      bus.in_funct3   = 3'b010;
      bus.in_addr     = 32'h8000_0040;
      @(posedge clk) #1;
      bus.in_valid = 1'b0;
      @(posedge clk) #1;
      chk("pre_rst_req", bus.lsu_reqValid, 1);
      #2 rst = 1'b0;
      #1;
      chk("rst_async_req", bus.lsu_reqValid, 0);
      chk("rst_async_rdy", bus.in_ready, 1);
      @(posedge clk) #1;
      rst = 1'b1;
      @(posedge clk) #1;
      chk("post_rst_rdy", bus.in_ready, 1);
      chk("post_rst_valid", bus.out_valid, 0);

      for (int i = 0; i < 150; i++) begin
         d  = $urandom_range(0, 9);
         ld = (d < 5) ? 1'b1 : (d == 9);
         st = (d >= 5);
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) f3 = {f3[2] & ld, f3[1:0]};
         a  = $urandom;
         if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
         do_op(ld, st, f3, a, $urandom, $urandom,
               $urandom_range(0, TO + 1), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator: the requesting end of the LSU memory port whose responder is the pmem DPI memory model.
- Accepts one load/store op from the execute stage and aligns the store data and byte mask.
- Drives the memory request with the valid/response handshake, waits for the response, then extracts and extends the load data.
- Returns the result with a valid/ready handshake and reports misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 255: request cycles without lsu_respValid before abort (1..255).
- CNT_W, 8: timeout counter width.

Ports:
- clk  in  1  clock (single clock domain).
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  op offered by the execute stage.
- in_ready  out  1  block can accept an op.
- in_is_load  in  1  op is a load.
- in_is_store  in  1  op is a store.
- in_funct3  in  3  RV32 width/sign code.
- in_addr  in  32  effective byte address.
- in_wdata  in  32  store data, unaligned (value in low bits).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_rdata  out  32  extended load data; 0 for stores and errors.
- out_err  out  1  op failed.
- out_err_cause  out  2  01 misaligned, 10 illegal, 11 timeout, 00 none.
- lsu_reqValid  out  1  memory request.
- lsu_respValid  in  1  memory response.
- lsu_addr  out  32  word address {addr[31:2],2'b00}.
- lsu_wen  out  1  1 = write.
- lsu_wdata  out  32  store data shifted by 8*addr[1:0].
- lsu_wmask  out  4  byte-lane mask.
- lsu_rdata  in  32  read word.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; counter is cleared.
  - All lsu_* outputs, out_valid, out_rdata, out_err and out_err_cause are 0.
  - in_ready = 1, because it is combinational: in_ready = (state==IDLE).
  - Reset asserted mid-request drops lsu_reqValid immediately; the in-flight op is discarded.
- States:
  - IDLE: on in_valid && in_ready, decode the op.
    - Legal and aligned: register the request fields and go to REQ.
    - Otherwise: load the error result and go to DONE.
  - REQ: lsu_reqValid = 1, with lsu_addr, lsu_wen, lsu_wdata and lsu_wmask held stable.
    - The counter increments each cycle lsu_respValid = 0.
    - On lsu_respValid = 1, capture lsu_rdata (loads) and go to DONE; lsu_reqValid is 0 from the next cycle.
    - If the counter reaches TIMEOUT_CYCLES, set err cause 11 and go to DONE. No further request is issued.
  - DONE: out_valid = 1 with result fields stable.
    - On out_ready, go to IDLE next cycle; out_valid drops.
    - No new op is accepted in the same cycle.
- Latency with a zero-wait responder (respValid asserted in the same cycle as reqValid):
  - Accept at cycle T; lsu_reqValid at T+1; out_valid at T+2; in_ready again at T+3 if out_ready is held.
  - Each extra wait cycle adds one cycle.
- Decode:
  - Illegal (cause 10):
    - both or neither of in_is_load/in_is_store;
    - load funct3 not in {000,001,010,100,101};
    - store funct3 not in {000,001,010}.
  - Misaligned (cause 01):
    - halfword with addr[0]=1;
    - word with addr[1:0]≠0.
    - Illegal takes precedence over misaligned.
- Store masks, with off = addr[1:0]:
  - SB: 4'b0001<<off.
  - SH: 4'b0011<<off.
  - SW: 4'b1111.
  - lsu_wdata = in_wdata << (8*off).
- Loads:
  - lsu_wen = 0 and lsu_wmask = 0.
  - shifted = lsu_rdata >> (8*off).
  - LB/LH are sign-extended from bit 7/15; LBU/LHU are zero-extended; LW is passed through.
- Stores report out_rdata = 0 and out_err = 0 on response.
- Counter saturates at TIMEOUT_CYCLES, is never compared in IDLE, and is cleared on entering REQ.

Test Plan:
- LW addr 0x80000004, responder returns 0xDEADBEEF with zero wait:
  - lsu_addr = 0x80000004 and reqValid at T+1; out_valid at T+2 with rdata 0xDEADBEEF, err 0.
- LB addr 0x80000003, rdata 0x80FF1234:
  - out_rdata = 0xFFFFFF80.
  - LBU at the same address gives 0x00000080.
  - LHU at 0x80000002 gives 0x000080FF.
- SH addr 0x80000002, wdata 0x0000ABCD:
  - lsu_wen = 1, wmask = 4'b1100, lsu_wdata = 0xABCD0000, lsu_addr = 0x80000000.
  - Responder delays respValid by 3 cycles: request fields stay stable throughout; out_valid one cycle after the response.
- Errors, none of which ever asserts lsu_reqValid:
  - LW addr 0x80000002 gives out_err = 1, cause 01.
  - Load funct3 = 011 gives cause 10.
  - in_is_load = in_is_store = 1 gives cause 10.
- Timeout and recovery:
  - Responder never answers with TIMEOUT_CYCLES = 4: out_valid with cause 11 and reqValid deasserted.
  - A following legal SW completes normally.
- Backpressure and reset:
  - out_ready held 0 for 5 cycles: out_valid and out_rdata stay stable and in_ready stays 0.
  - rst pulsed low during REQ: lsu_reqValid falls without waiting for a clock edge, and in_ready = 1 after release.
